// File: rtl/bus_master_arbiter.sv
// ============================================================================
// Module      : bus_master_arbiter
// Description : Round-robin arbiter that shares the single simple-bus master
//               port of bus_interconnect between N_MASTERS requesters.
//               It allows one outstanding transaction at a time. Each grant
//               drives a one-cycle m_valid pulse. The fixed next-cycle
//               response is routed back to the granted requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : N_MASTERS  number of requesters (2..8); requester 0 wins
//                          first after reset
// Ports       : clk, rst_n                 clock, async active-low reset
//               s_valid/s_write/s_lock [N] per-requester request controls
//               s_addr/s_wdata [N*32]      requester i at [32*i +: 32]
//               s_wstrb [N*4]              requester i at [4*i +: 4]
//               s_ready/s_rvalid [N]       completion pulses to requesters
//               s_rdata [32]               broadcast read data
//               m_valid/m_write/m_addr/m_wdata/m_wstrb  to bus_interconnect
//               m_ready/m_rvalid/m_rdata   response from bus_interconnect
//               gnt_idx [3]                last/current granted requester
//               arb_err                    missing-response pulse
// Options     : BUS_ARB_LOCK_EN - honour s_lock so that a requester can hold
//               the grant across consecutive transactions
// ============================================================================
`default_nettype none

module bus_master_arbiter #(
  parameter int N_MASTERS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MASTERS-1:0]    s_valid,
  input  logic [N_MASTERS-1:0]    s_write,
  input  logic [N_MASTERS*32-1:0] s_addr,
  input  logic [N_MASTERS*32-1:0] s_wdata,
  input  logic [N_MASTERS*4-1:0]  s_wstrb,
  input  logic [N_MASTERS-1:0]    s_lock,
  output logic [N_MASTERS-1:0]    s_ready,
  output logic [N_MASTERS-1:0]    s_rvalid,
  output logic [31:0]             s_rdata,
  output logic                    m_valid,
  output logic                    m_write,
  output logic [31:0]             m_addr,
  output logic [31:0]             m_wdata,
  output logic [3:0]              m_wstrb,
  input  logic                    m_ready,
  input  logic                    m_rvalid,
  input  logic [31:0]             m_rdata,
  output logic [2:0]              gnt_idx,
  output logic                    arb_err
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_rr_ptr;
  logic [2:0] r_gnt_idx;
  logic       r_write;
  logic       r_lock;

  logic [7:0] w_req;
  logic [2:0] w_sel;
  logic       w_any;
  logic       w_sel_write;
  logic       w_sel_lock;
  logic       w_wait;

  assign w_any  = |s_valid;
  assign w_wait = (r_state == c_WAIT);

  // Scan rr_ptr, rr_ptr+1, ... (mod N) for the first requester. w_req is
  // zero-padded to 8 bits so that the scan index never exceeds the vector.
  always_comb begin
    logic [3:0] v_idx;
    logic       v_found;
    w_req                = '0;
    w_req[N_MASTERS-1:0] = s_valid;
    w_sel                = r_rr_ptr;
    v_found              = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      v_idx = {1'b0, r_rr_ptr} + 4'(k);
      if (v_idx >= 4'(N_MASTERS)) v_idx = v_idx - 4'(N_MASTERS);
      if (!v_found && w_req[v_idx[2:0]]) begin
        v_found = 1'b1;
        w_sel   = v_idx[2:0];
      end
    end
`ifdef BUS_ARB_LOCK_EN
    // A live lock overrides round-robin while the holder keeps requesting.
    if (r_lock && w_req[r_gnt_idx]) w_sel = r_gnt_idx;
`endif
  end

  // Request fields of the selected requester, zero when nothing is issued.
  always_comb begin
    m_addr      = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    w_sel_write = 1'b0;
    w_sel_lock  = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!w_wait && w_any && (w_sel == 3'(i))) begin
        m_addr      = s_addr[32*i +: 32];
        m_wdata     = s_wdata[32*i +: 32];
        m_wstrb     = s_wstrb[4*i +: 4];
        w_sel_write = s_write[i];
`ifdef BUS_ARB_LOCK_EN
        w_sel_lock  = s_lock[i];
`endif
      end
    end
  end

`ifndef BUS_ARB_LOCK_EN
  logic w_unused_lock;
  assign w_unused_lock = &{1'b0, s_lock};
`endif

  // Gating with rst_n keeps m_valid low while reset is held, even though
  // requesters may already be asserting s_valid.
  assign m_valid = !w_wait && w_any && rst_n;
  assign m_write = w_sel_write;

  // Response routing. A missing response is replaced by a synthesized
  // completion that matches the latched direction, so the requester never
  // hangs.
  always_comb begin
    s_ready  = '0;
    s_rvalid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_wait && (r_gnt_idx == 3'(i))) begin
        s_ready[i]  = m_ready  || (!m_rvalid && r_write);
        s_rvalid[i] = m_rvalid || (!m_ready && !r_write);
      end
    end
  end

  assign s_rdata = (w_wait && m_rvalid) ? m_rdata : 32'h0;
  assign arb_err = w_wait && !m_ready && !m_rvalid;
  assign gnt_idx = r_gnt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_write   <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // An issue reloads the lock from the new holder. An IDLE cycle with
          // no request at all also means the holder is idle, which drops it.
          r_lock <= w_any ? w_sel_lock : 1'b0;
          if (w_any) begin
            r_state   <= c_WAIT;
            r_gnt_idx <= w_sel;
            r_write   <= w_sel_write;
          end
        end
        default: begin
          r_state <= c_IDLE;
          if (!r_lock) begin
            r_rr_ptr <= (r_gnt_idx == 3'(N_MASTERS - 1)) ? 3'd0 : r_gnt_idx + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
